dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_if.sv | 44 ++++
 rtl/dmem_arbiter.sv | 114 +++++++++++
 tb/tb_dmem_arbiter.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between two data-memory requesters, the arbiter and the memory.
// The arbiter uses the slave modport. The master modport is the
// requester/memory environment side.
interface dmem_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 10
);
  logic                  req0_valid;
  logic                  req0_ready;
  logic                  req0_we;
  logic [ADDR_WIDTH-1:0] req0_addr;
  logic [DATA_WIDTH-1:0] req0_wdata;
  logic                  req1_valid;
  logic                  req1_ready;
  logic                  req1_we;
  logic [ADDR_WIDTH-1:0] req1_addr;
  logic [DATA_WIDTH-1:0] req1_wdata;
  logic                  rsp0_valid;
  logic [DATA_WIDTH-1:0] rsp0_rdata;
  logic                  rsp1_valid;
  logic [DATA_WIDTH-1:0] rsp1_rdata;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  req0_valid, req0_we, req0_addr, req0_wdata,
    input  req1_valid, req1_we, req1_addr, req1_wdata,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata,
    output mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output req0_valid, req0_we, req0_addr, req0_wdata,
    output req1_valid, req1_we, req1_addr, req1_wdata,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata,
    input  mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter. One access is made every two cycles:
// accept, then memory access, then a response pulse to the owner.
// Optional feature macro: DMEM_ARB_ROUND_ROBIN_EN.
// - When defined, ties go to the requester not granted last.
// - When undefined, fixed priority applies and requester 0 wins ties.
module dmem_arbiter #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic           i_clk,
  input  logic           i_arst,
  dmem_arbiter_if.slave  bus
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                state;
  logic                  lat_we;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic                  lat_id;
  logic                  rsp0_valid;
  logic                  rsp1_valid;
  logic [DATA_WIDTH-1:0] rsp0_rdata;
  logic [DATA_WIDTH-1:0] rsp1_rdata;
  logic                  grant0;
  logic                  grant1;
  logic                  accept;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
  logic                  last_id;
`endif

  // Winner selection. Only in IDLE, and never while reset is being sampled.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE && !i_arst) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      if (bus.req0_valid && bus.req1_valid) begin
        grant0 = last_id;
        grant1 = !last_id;
      end else begin
        grant0 = bus.req0_valid;
        grant1 = bus.req1_valid;
      end
`else
      grant0 = bus.req0_valid;
      grant1 = bus.req1_valid && !bus.req0_valid;
`endif
    end
  end

  assign accept         = grant0 || grant1;
  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;

  // Memory port carries the latched request only during ACCESS; otherwise all zero.
  assign bus.mem_we    = (state == ACCESS) && lat_we;
  assign bus.mem_addr  = (state == ACCESS) ? lat_addr  : '0;
  assign bus.mem_wdata = (state == ACCESS) ? lat_wdata : '0;

  assign bus.rsp0_valid = rsp0_valid;
  assign bus.rsp1_valid = rsp1_valid;
  assign bus.rsp0_rdata = rsp0_rdata;
  assign bus.rsp1_rdata = rsp1_rdata;

  // FSM, request latch and response registers.
  // Reset inside ACCESS drops the response.
  always_ff @(posedge i_clk) begin
    if (i_arst) begin
      state      <= IDLE;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_id     <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp0_rdata <= '0;
      rsp1_rdata <= '0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      last_id    <= 1'b1;
`endif
    end else begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            lat_we    <= grant1 ? bus.req1_we    : bus.req0_we;
            lat_addr  <= grant1 ? bus.req1_addr  : bus.req0_addr;
            lat_wdata <= grant1 ? bus.req1_wdata : bus.req0_wdata;
            lat_id    <= grant1;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            last_id   <= grant1;
`endif
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (lat_id) begin
            rsp1_valid <= 1'b1;
            rsp1_rdata <= bus.mem_rdata;
          end else begin
            rsp0_valid <= 1'b1;
            rsp0_rdata <= bus.mem_rdata;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter.
// Uses a small word memory model indexed by byte address bits [6:3].
module tb_dmem_arbiter;

  localparam int unsigned DW = 64;
  localparam int unsigned AW = 10;

  logic clk;
  logic arst;
  int   total;
  int   passed;

  dmem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  dmem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .i_clk  (clk),
    .i_arst (arst),
    .bus    (bus.slave)
  );

  // Combinational-read memory with preloaded words at 0x20..0x50.
  logic [DW-1:0] mem [0:15] = '{64'h0, 64'h0, 64'h0, 64'h0,
                                64'h1111, 64'h2222, 64'h3333, 64'h4444,
                                64'h5555, 64'h6666, 64'h7777, 64'h0,
                                64'h0, 64'h0, 64'h0, 64'h0};

  assign bus.mem_rdata = mem[bus.mem_addr[6:3]];

  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr[6:3]] <= bus.mem_wdata;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  int            g;
  int            prev_g;
  int            exp_g [4];
  logic [DW-1:0] exp_d [4];
  logic [DW-1:0] last0;
  logic [DW-1:0] last1;
  logic [AW-1:0] a0;
  logic [AW-1:0] a1;

  initial begin
    total  = 0;
    passed = 0;
    arst   = 1'b1;
    bus.req0_valid = 1'b0; bus.req0_we = 1'b0; bus.req0_addr = '0; bus.req0_wdata = '0;
    bus.req1_valid = 1'b0; bus.req1_we = 1'b0; bus.req1_addr = '0; bus.req1_wdata = '0;

    // Reset: readies held low in the reset cycle, registered outputs cleared.
    tick();
    tick();
    bus.req0_valid = 1'b1;
    #1;
    chk("ready0_in_reset", bus.req0_ready, 0);
    chk("rst_rsp_valids", {bus.rsp0_valid, bus.rsp1_valid}, 0);
    chk("rst_rdata0", bus.rsp0_rdata, 0);
    chk("rst_rdata1", bus.rsp1_rdata, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    bus.req0_valid = 1'b0;
    arst = 1'b0;
    tick();

    // req0 writes 0xAAAA to 0x010.
    bus.req0_valid = 1'b1; bus.req0_we = 1'b1; bus.req0_addr = 10'h010; bus.req0_wdata = 64'hAAAA;
    #1;
    chk("wr_ready0", bus.req0_ready, 1);
    chk("wr_ready1", bus.req1_ready, 0);
    tick();
    bus.req0_valid = 1'b0; bus.req0_we = 1'b0;
    #1;
    chk("wr_mem_we", bus.mem_we, 1);
    chk("wr_mem_addr", bus.mem_addr, 10'h010);
    chk("wr_mem_wdata", bus.mem_wdata, 64'hAAAA);
    chk("wr_no_ready_access", {bus.req0_ready, bus.req1_ready}, 0);
    tick();
    chk("wr_rsp0_valid", bus.rsp0_valid, 1);
    chk("wr_rsp1_valid", bus.rsp1_valid, 0);
    chk("wr_rsp0_prewrite", bus.rsp0_rdata, 0);
    chk("wr_mem_idle", {bus.mem_we, bus.mem_addr, bus.mem_wdata}, 0);
    tick();
    chk("wr_rsp0_pulse_end", bus.rsp0_valid, 0);

    // req1 reads back 0x010.
    bus.req1_valid = 1'b1; bus.req1_we = 1'b0; bus.req1_addr = 10'h010;
    #1;
    chk("rd_ready1", bus.req1_ready, 1);
    chk("rd_ready0", bus.req0_ready, 0);
    tick();
    bus.req1_valid = 1'b0;
    #1;
    chk("rd_mem_we", bus.mem_we, 0);
    chk("rd_mem_addr", bus.mem_addr, 10'h010);
    tick();
    chk("rd_rsp1_valid", bus.rsp1_valid, 1);
    chk("rd_rsp0_valid", bus.rsp0_valid, 0);
    chk("rd_rsp1_rdata", bus.rsp1_rdata, 64'hAAAA);
    chk("rd_rsp0_hold", bus.rsp0_rdata, 0);
    tick();

    // Both requesters continuously valid, four back-to-back reads.
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    exp_g = '{0, 1, 0, 1};
    exp_d = '{64'h1111, 64'h2222, 64'h3333, 64'h4444};
`else
    exp_g = '{0, 0, 0, 0};
    exp_d = '{64'h1111, 64'h3333, 64'h5555, 64'h7777};
`endif
    last0 = 64'h0;
    last1 = 64'hAAAA;
    prev_g = 0;
    a0 = 10'h020;
    a1 = 10'h028;
    bus.req0_valid = 1'b1; bus.req0_we = 1'b0; bus.req0_addr = a0;
    bus.req1_valid = 1'b1; bus.req1_we = 1'b0; bus.req1_addr = a1;
    for (int k = 0; k < 4; k++) begin
      #1;
      g = exp_g[k];
      chk($sformatf("b2b_ready0_%0d", k), bus.req0_ready, (g == 0) ? 1 : 0);
      chk($sformatf("b2b_ready1_%0d", k), bus.req1_ready, (g == 1) ? 1 : 0);
      if (k > 0) begin
        chk($sformatf("b2b_rsp_%0d", k - 1), {bus.rsp0_valid, bus.rsp1_valid},
            (prev_g == 0) ? 2'b10 : 2'b01);
        chk($sformatf("b2b_rdata_%0d", k - 1), {bus.rsp0_rdata, bus.rsp1_rdata}, {last0, last1});
      end
      tick();
      if (g == 0) begin
        a0 = a0 + 10'h010;
        bus.req0_addr = a0;
        last0 = exp_d[k];
      end else begin
        a1 = a1 + 10'h010;
        bus.req1_addr = a1;
        last1 = exp_d[k];
      end
      if (k == 3) begin
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
      end
      prev_g = g;
      #1;
      chk($sformatf("b2b_access_quiet_%0d", k),
          {bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid}, 0);
      tick();
    end
    chk("b2b_rsp_3", {bus.rsp0_valid, bus.rsp1_valid}, (prev_g == 0) ? 2'b10 : 2'b01);
    chk("b2b_rdata_3", {bus.rsp0_rdata, bus.rsp1_rdata}, {last0, last1});
    tick();
    chk("b2b_pulse_end", {bus.rsp0_valid, bus.rsp1_valid}, 0);

    // Reset during the ACCESS cycle of a read by a lone req1.
    bus.req1_valid = 1'b1; bus.req1_we = 1'b0; bus.req1_addr = 10'h028;
    #1;
    chk("lone_ready1", bus.req1_ready, 1);
    tick();
    bus.req1_valid = 1'b0;
    arst = 1'b1;
    tick();
    chk("rstacc_rsp_valids", {bus.rsp0_valid, bus.rsp1_valid}, 0);
    chk("rstacc_rdata", {bus.rsp0_rdata, bus.rsp1_rdata}, 0);
    arst = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_we = 1'b0; bus.req0_addr = 10'h020;
    #1;
    chk("rstacc_idle_ready0", bus.req0_ready, 1);
    tick();
    bus.req0_valid = 1'b0;
    tick();
    chk("rstacc_rsp0_valid", bus.rsp0_valid, 1);
    chk("rstacc_rsp0_rdata", bus.rsp0_rdata, 64'h1111);
    tick();

    // Ten idle cycles: everything quiet.
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("idle_quiet_%0d", i),
          {bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.req0_ready, bus.req1_ready,
           bus.rsp0_valid, bus.rsp1_valid}, 0);
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
